// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU op/select codes,
// enable levels and the ID/EX slot state encoding.
package id_pipe_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned NOP_REG_ADDR = 0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_AND = 8'h24;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR = 8'h27;
  localparam logic [7:0] ALU_SLL = 8'h7C;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;
  localparam logic [7:0] ALU_LW  = 8'hE3;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_LOAD  = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_LUSTALL
  } state_t;

endpackage

// File: rtl/id_pipe_decode.sv
// Combinational instruction decoder: ALU op/class, operand read enables,
// destination register and immediate.
module id_decode
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst,
  output logic [7:0]        aluop,
  output logic [2:0]        alusel,
  output logic              reg1_read,
  output logic              reg2_read,
  output logic [REG_AW-1:0] wd,
  output logic              wreg,
  output logic [DATA_W-1:0] imm,
  output logic              invalid
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rt    = REG_AW'(inst[20:16]);
  assign rd    = REG_AW'(inst[15:11]);

  always_comb begin
    aluop     = ALU_NOP;
    alusel    = SEL_NOP;
    reg1_read = DISABLE;
    reg2_read = DISABLE;
    wd        = REG_AW'(NOP_REG_ADDR);
    wreg      = DISABLE;
    imm       = '0;
    invalid   = 1'b0;
    unique case (op)
      OP_SPECIAL: begin
        wd = rd;
        unique case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            wreg      = ENABLE;
            reg1_read = ENABLE;
            reg2_read = ENABLE;
            alusel    = SEL_LOGIC;
            unique case (funct)
              FN_AND:  aluop = ALU_AND;
              FN_OR:   aluop = ALU_OR;
              FN_XOR:  aluop = ALU_XOR;
              default: aluop = ALU_NOR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // shamt replaces rs as operand 1
            wreg      = ENABLE;
            reg2_read = ENABLE;
            imm       = DATA_W'(inst[10:6]);
            alusel    = SEL_SHIFT;
            unique case (funct)
              FN_SLL:  aluop = ALU_SLL;
              FN_SRL:  aluop = ALU_SRL;
              default: aluop = ALU_SRA;
            endcase
          end
          default: begin
            wd      = REG_AW'(NOP_REG_ADDR);
            invalid = 1'b1;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        wd        = rt;
        wreg      = ENABLE;
        reg1_read = ENABLE;
        imm       = DATA_W'(inst[15:0]);
        alusel    = SEL_LOGIC;
        unique case (op)
          OP_ANDI: aluop = ALU_AND;
          OP_ORI:  aluop = ALU_OR;
          default: aluop = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        wd        = rt;
        wreg      = ENABLE;
        reg1_read = ENABLE;
        imm       = DATA_W'({inst[15:0], 16'h0000});
        aluop     = ALU_OR;
        alusel    = SEL_LOGIC;
      end
      OP_LW: begin
        wd        = rt;
        wreg      = ENABLE;
        reg1_read = ENABLE;
        imm       = DATA_W'($signed(inst[15:0]));
        aluop     = ALU_LW;
        alusel    = SEL_LOAD;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_pipe.sv
// ID stage: decode, EX/MEM forwarding, load-use hazard detection and a
// valid/ready ID/EX output slot with a saturating load-use stall counter.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              inst_invalid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [REG_AW-1:0] dec_wd;
  logic              dec_wreg;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_invalid;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              load_use;
  logic              accept;
  state_t            state, state_next;

  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .inst      (inst_i),
    .aluop     (dec_aluop),
    .alusel    (dec_alusel),
    .reg1_read (reg1_read_o),
    .reg2_read (reg2_read_o),
    .wd        (dec_wd),
    .wreg      (dec_wreg),
    .imm       (dec_imm),
    .invalid   (dec_invalid)
  );

  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  // $0 is hard-wired to zero ahead of any forwarding match
  always_comb begin
    op1 = dec_imm;
    if (reg1_read_o) begin
      if (reg1_addr_o == '0)                        op1 = '0;
      else if (ex_wreg_i && ex_wd_i == reg1_addr_o)   op1 = ex_wdata_i;
      else if (mem_wreg_i && mem_wd_i == reg1_addr_o) op1 = mem_wdata_i;
      else                                            op1 = reg1_data_i;
    end
    op2 = dec_imm;
    if (reg2_read_o) begin
      if (reg2_addr_o == '0)                        op2 = '0;
      else if (ex_wreg_i && ex_wd_i == reg2_addr_o)   op2 = ex_wdata_i;
      else if (mem_wreg_i && mem_wd_i == reg2_addr_o) op2 = mem_wdata_i;
      else                                            op2 = reg2_data_i;
    end
  end

  assign load_use = in_valid && ex_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                    ((reg1_read_o && ex_wd_i == reg1_addr_o) ||
                     (reg2_read_o && ex_wd_i == reg2_addr_o));
  assign in_ready = !rst && !load_use && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = ST_RUN;
    if (rst)                         state_next = ST_RUN;
    else if (out_valid && !out_ready) state_next = ST_HOLD;
    else if (load_use)               state_next = ST_LUSTALL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      stall_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (state == ST_LUSTALL && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      aluop_o        <= ALU_NOP;
      alusel_o       <= SEL_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= DISABLE;
      pc_o           <= '0;
      inst_invalid_o <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      aluop_o        <= dec_aluop;
      alusel_o       <= dec_alusel;
      reg1_o         <= op1;
      reg2_o         <= op2;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      pc_o           <= pc_i;
      inst_invalid_o <= dec_invalid;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed testbench for id_pipe with hand-computed expected values.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        reg1_read_o;
  logic [4:0]  reg1_addr_o;
  logic [31:0] reg1_data_i;
  logic        reg2_read_o;
  logic [4:0]  reg2_addr_o;
  logic [31:0] reg2_data_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] pc_o;
  logic        inst_invalid_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .inst_invalid_o(inst_invalid_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    checks++; if ({aluop_o, alusel_o, wd_o, wreg_o, inst_invalid_o} !== 19'h0) begin errors++;
      $display("FAIL reset_ctrl got %0h %0h %0h %0h %0h want 0", aluop_o, alusel_o, wd_o, wreg_o, inst_invalid_o); end
    checks++; if ({reg1_o, reg2_o, pc_o} !== 96'h0) begin errors++;
      $display("FAIL reset_data got %0h %0h %0h want 0", reg1_o, reg2_o, pc_o); end
    checks++; if (stall_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt_o); end
    rst = 1'b0;
  endtask

  task automatic test_ori();
    in_valid = 1'b1; inst_i = 32'h3401_1100; pc_i = 32'h0000_0100; reg1_data_i = 32'h1234_5678;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ori_in_ready got %0h want 1", in_ready); end
    checks++; if ({reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o} !== {1'b1, 1'b0, 5'd0, 5'd1}) begin errors++;
      $display("FAIL ori_rf_ports got %0h %0h %0h %0h want 1 0 0 1", reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ori_out_valid got %0h want 1", out_valid); end
    checks++; if ({aluop_o, alusel_o} !== {8'h25, 3'b001}) begin errors++; $display("FAIL ori_aluop got %0h %0h want 25 1", aluop_o, alusel_o); end
    checks++; if (reg1_o !== 32'h0) begin errors++; $display("FAIL ori_reg1 got %0h want 0", reg1_o); end
    checks++; if (reg2_o !== 32'h0000_1100) begin errors++; $display("FAIL ori_reg2 got %0h want 1100", reg2_o); end
    checks++; if ({wd_o, wreg_o} !== {5'd1, 1'b1}) begin errors++; $display("FAIL ori_wd got %0h %0h want 1 1", wd_o, wreg_o); end
    checks++; if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL ori_pc got %0h want 100", pc_o); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ori_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_forward();
    in_valid = 1'b1; inst_i = 32'h0022_1825; pc_i = 32'h0000_0104;
    reg1_data_i = 32'h1111; reg2_data_i = 32'h2222;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h5555;
    step();
    checks++; if (reg1_o !== 32'hAAAA) begin errors++; $display("FAIL fwd_ex_prio got %0h want aaaa", reg1_o); end
    checks++; if (reg2_o !== 32'h2222) begin errors++; $display("FAIL fwd_rf_reg2 got %0h want 2222", reg2_o); end
    checks++; if ({wd_o, aluop_o} !== {5'd3, 8'h25}) begin errors++; $display("FAIL fwd_wd got %0h %0h want 3 25", wd_o, aluop_o); end
    ex_wreg_i = 1'b0; mem_wd_i = 5'd2;
    step();
    checks++; if ({reg1_o, reg2_o} !== {32'h1111, 32'h5555}) begin errors++;
      $display("FAIL fwd_mem got %0h %0h want 1111 5555", reg1_o, reg2_o); end
    in_valid = 1'b0; mem_wreg_i = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    ex_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'hDEAD;
    in_valid = 1'b1; inst_i = 32'h0045_2024; pc_i = 32'h0000_0108;
    reg1_data_i = 32'h3333; reg2_data_i = 32'h0F0F;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready got %0h want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0h want 0", out_valid); end
    ex_load_i = 1'b0; ex_wreg_i = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, aluop_o, wd_o} !== {1'b1, 8'h24, 5'd4}) begin errors++;
      $display("FAIL lu_issue got %0h %0h %0h want 1 24 4", out_valid, aluop_o, wd_o); end
    checks++; if ({reg1_o, reg2_o} !== {32'h3333, 32'h0F0F}) begin errors++;
      $display("FAIL lu_operands got %0h %0h want 3333 f0f", reg1_o, reg2_o); end
    checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0h want 1", stall_cnt_o); end
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; inst_i = 32'h0022_1825; pc_i = 32'h0000_0200;
    reg1_data_i = 32'h1111; reg2_data_i = 32'h2222; out_ready = 1'b1;
    step();
    out_ready = 1'b0; inst_i = 32'h3826_00FF; pc_i = 32'h0000_0204;
    reg1_data_i = 32'h9999; ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle %0d got %0h want 0", i, in_ready); end
      step();
      checks++; if ({out_valid, aluop_o, reg1_o, reg2_o, pc_o} !== {1'b1, 8'h25, 32'h1111, 32'h2222, 32'h200}) begin errors++;
        $display("FAIL hold_stable cycle %0d got %0h %0h %0h %0h %0h", i, out_valid, aluop_o, reg1_o, reg2_o, pc_o); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %0h want 1", in_ready); end
    step();
    checks++; if ({aluop_o, reg1_o, reg2_o, wd_o, pc_o} !== {8'h26, 32'hBEEF, 32'h00FF, 5'd6, 32'h204}) begin errors++;
      $display("FAIL b2b_xori got %0h %0h %0h %0h %0h", aluop_o, reg1_o, reg2_o, wd_o, pc_o); end
    inst_i = 32'h30C7_0F0F; pc_i = 32'h0000_0208; ex_wreg_i = 1'b0; reg1_data_i = 32'h00F0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0h want 1", in_ready); end
    step();
    checks++; if ({out_valid, aluop_o, reg1_o, reg2_o, wd_o} !== {1'b1, 8'h24, 32'h00F0, 32'h0F0F, 5'd7}) begin errors++;
      $display("FAIL b2b_andi got %0h %0h %0h %0h %0h", out_valid, aluop_o, reg1_o, reg2_o, wd_o); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_invalid_zero();
    in_valid = 1'b1; inst_i = 32'hFC00_0000; pc_i = 32'h0000_0300;
    step();
    checks++; if ({out_valid, inst_invalid_o, wreg_o, aluop_o} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin errors++;
      $display("FAIL invalid_op got %0h %0h %0h %0h want 1 1 0 0", out_valid, inst_invalid_o, wreg_o, aluop_o); end
    inst_i = 32'h0002_1825; reg1_data_i = 32'h0077; reg2_data_i = 32'h0042;
    ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hDEAD;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_no_lu got %0h want 1", in_ready); end
    step();
    checks++; if ({reg1_o, reg2_o, inst_invalid_o} !== {32'h0, 32'h0042, 1'b0}) begin errors++;
      $display("FAIL zero_fwd got %0h %0h %0h want 0 42 0", reg1_o, reg2_o, inst_invalid_o); end
    ex_wreg_i = 1'b0; ex_load_i = 1'b0;
    inst_i = 32'h3C07_ABCD;
    step();
    checks++; if ({reg1_o, reg2_o, aluop_o, wd_o} !== {32'h0, 32'hABCD_0000, 8'h25, 5'd7}) begin errors++;
      $display("FAIL lui got %0h %0h %0h %0h", reg1_o, reg2_o, aluop_o, wd_o); end
    inst_i = 32'h8D28_FFFC; reg1_data_i = 32'h1000;
    step();
    checks++; if ({reg1_o, reg2_o, aluop_o, alusel_o, wd_o, wreg_o} !== {32'h1000, 32'hFFFF_FFFC, 8'hE3, 3'b111, 5'd8, 1'b1}) begin errors++;
      $display("FAIL lw got %0h %0h %0h %0h %0h %0h", reg1_o, reg2_o, aluop_o, alusel_o, wd_o, wreg_o); end
    inst_i = 32'h000B_5142; reg2_data_i = 32'h8000_0000;
    #1;
    checks++; if ({reg1_read_o, reg2_read_o} !== 2'b01) begin errors++; $display("FAIL srl_reads got %0h %0h want 0 1", reg1_read_o, reg2_read_o); end
    step();
    checks++; if ({reg1_o, reg2_o, aluop_o, alusel_o, wd_o} !== {32'h5, 32'h8000_0000, 8'h02, 3'b010, 5'd10}) begin errors++;
      $display("FAIL srl got %0h %0h %0h %0h %0h", reg1_o, reg2_o, aluop_o, alusel_o, wd_o); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; inst_i = 32'h3401_1100; pc_i = 32'h0000_0400; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_loaded got %0h want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got %0h want 0", in_ready); end
    step();
    checks++; if ({out_valid, stall_cnt_o} !== 17'h0) begin errors++;
      $display("FAIL rmid_clear got %0h %0h want 0 0", out_valid, stall_cnt_o); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_i = '0; inst_i = '0;
    reg1_data_i = '0; reg2_data_i = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0; out_ready = 1'b1;
    test_reset();
    test_ori();
    test_forward();
    test_load_use();
    test_back_to_back();
    test_invalid_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath and operand width.
REQ-002 SHALL provide parameter REG_AW, default 5, register address width.
REQ-003 SHALL provide parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have one clock and synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous reset, active high.
REQ-005 SHALL have the following IF-side ports:
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts this cycle.
- pc_i  in  DATA_W  instruction address.
- inst_i  in  32  instruction word.
REQ-006 SHALL have the following register-file ports:
- reg1_read_o  out  1  read enable, port 1.
- reg1_addr_o  out  REG_AW  rs.
- reg1_data_i  in  DATA_W  rs data.
- reg2_read_o  out  1  read enable, port 2.
- reg2_addr_o  out  REG_AW  rt.
- reg2_data_i  in  DATA_W  rt data.
REQ-007 SHALL have the following forwarding ports:
- ex_wreg_i  in  1  EX write enable.
- ex_wd_i  in  REG_AW  EX destination.
- ex_wdata_i  in  DATA_W  EX result.
- ex_load_i  in  1  EX holds a load.
- mem_wreg_i  in  1  MEM write enable.
- mem_wd_i  in  REG_AW  MEM destination.
- mem_wdata_i  in  DATA_W  MEM result.
REQ-008 SHALL have the following EX-side ports:
- out_valid  out  1  registered ID/EX slot holds a valid instruction.
- out_ready  in  1  EX consumes.
- aluop_o  out  8  ALU operation.
- alusel_o  out  3  result class.
- reg1_o  out  DATA_W  operand 1.
- reg2_o  out  DATA_W  operand 2.
- wd_o  out  REG_AW  destination.
- wreg_o  out  1  writeback enable.
- pc_o  out  DATA_W  instruction address.
- inst_invalid_o  out  1  undecodable opcode.
- stall_cnt_o  out  CNT_W  load-use stall count.

Function
REQ-009 SHALL decode combinationally, with registered outputs:
- ORI/ANDI/XORI: zero-extended immediate.
- LUI: imm<<16.
- SPECIAL AND/OR/XOR/NOR/SLL/SRL/SRA: shamt zero-extended into operand 1.
- LW: sign-extended offset into operand 2; wreg=1.
REQ-010 SHALL assert reg1_read_o/reg2_read_o only for operands the decoded instruction uses; the addresses SHALL always carry rs/rt.
REQ-011 SHALL substitute the immediate for an operand whose read is disabled.
REQ-012 SHALL select forwarding with priority EX (ex_wreg_i, ex_wd_i match) > MEM > register file; register 0 SHALL always read 0 and never be forwarded.
REQ-013 SHALL treat an unknown opcode/funct as NOP (aluop NOP, wreg 0) with inst_invalid_o=1, still issued.
REQ-014 SHALL detect load-use: ex_load_i & ex_wreg_i & ex_wd_i!=0 & ex_wd_i equals a read-enabled address while in_valid.
REQ-015 SHALL define in_ready = !rst & !load_use & (!out_valid | out_ready).
REQ-016 SHALL capture decode, operands and pc_i into the ID/EX slot on in_valid&in_ready; out_valid=1 next cycle (latency 1).
REQ-017 SHALL set out_valid=0 on out_valid&out_ready without accept; this is the bubble during load-use.
REQ-018 SHALL hold all slot outputs stable while out_valid&!out_ready.
REQ-019 SHALL sample operands only on the accept cycle; held slots SHALL NOT re-forward.
REQ-020 SHALL implement states RUN, HOLD (out_valid&!out_ready), LUSTALL (load_use); HOLD takes precedence over LUSTALL when both apply.
REQ-021 SHALL increment stall_cnt_o once per LUSTALL cycle, saturating at all-ones.

Reset
REQ-022 SHALL on rst set out_valid=0, aluop=NOP, alusel=NOP, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, pc_o=0, inst_invalid_o=0, stall_cnt_o=0, state=RUN.
REQ-023 SHALL on rst mid-transfer drop the slot without issue; in_ready=0 during rst.

Structure
REQ-024 SHALL keep opcode/funct codes, aluop/alusel codes, NOP register address and the Enable/Disable constants in the shared defines package.
REQ-025 SHALL split decode into one combinational sub-module id_decode; forwarding, hazard and slot logic stay in id_pipe.

Verification
REQ-026 SHALL cover: reset, then ORI $1,$0,0x1100 -> next cycle out_valid=1, aluop=OR, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1.
REQ-027 SHALL cover: OR $3,$1,$2 with ex_wd_i=1 (0xAAAA) and mem_wd_i=1 (0x5555) both valid -> reg1_o=0xAAAA.
REQ-028 SHALL cover: ex_load_i=1, ex_wd_i=2, then AND $4,$2,$5 presented -> in_ready=0 one cycle, stall_cnt_o=1, then issue after ex_load_i drops.
REQ-029 SHALL cover: out_ready=0 for 3 cycles after issue -> outputs unchanged, in_ready=0, then one issue per cycle resumes.
REQ-030 SHALL cover: inst_i=0xFC000000 -> inst_invalid_o=1, wreg_o=0; a write to $0 forwarded from EX -> operand reads 0.
REQ-031 SHALL cover: rst asserted while out_valid=1 -> next cycle out_valid=0, stall_cnt_o=0.
